int_requester: RTL and testbench

INT_REQUESTER -- requirements
Module: int_requester

---
 rtl/int_requester_if.sv | 16 +
 rtl/int_requester.sv | 120 ++++++++++++
 tb/tb_int_requester.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/int_requester_if.sv
// Button/CPU interrupt bus: raw buttons, mask and CPU handshake in, request, code and status flags out.
interface int_requester_if;
  logic [2:0] btn;
  logic [2:0] mask;
  logic       ie;
  logic       ack;
  logic       eret;
  logic       BK;
  logic [1:0] code;
  logic [2:0] pending;
  logic [2:0] leds;

  // master = requester side, slave = CPU/board side
  modport master (input btn, mask, ie, ack, eret, output BK, code, pending, leds);
  modport slave  (output btn, mask, ie, ack, eret, input BK, code, pending, leds);
endinterface

// File: rtl/int_requester.sv
// Debounced 3-source priority interrupt requester; BK rises 2 cycles after a debounced press, held until ack or ie drop.
// Optional INT_NEST_EN macro permits preemption by a source above the highest in-service one.
module int_requester #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic            clk,
  input logic            in_RST,
  int_requester_if.master bus
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       acc_q, acc_d, acc_prev_q;
  logic [2:0][15:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       leds_q, leds_d;
  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;

  logic [2:0] elig, ack_set, eret_clr;
  logic       cand_vld, leds_any, permit;
  logic [1:0] cand_idx, leds_top;

  always_comb begin
    acc_d = acc_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == DB_LAST) acc_d[i] = ~acc_q[i];
        else                      cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    elig     = pend_q & bus.mask;
    cand_vld = |elig;
    cand_idx = 2'd0;
    if (elig[2])      cand_idx = 2'd2;
    else if (elig[1]) cand_idx = 2'd1;
    leds_any = |leds_q;
    leds_top = 2'd0;
    if (leds_q[2])      leds_top = 2'd2;
    else if (leds_q[1]) leds_top = 2'd1;
`ifdef INT_NEST_EN
    permit = !leds_any || (cand_idx > leds_top);
`else
    permit = !leds_any;
`endif
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ack_set = '0;
    case (state_q)
      IDLE: begin
        if (bus.ie && cand_vld && permit) begin
          state_d = REQ;
          code_d  = cand_idx + 2'd1;
        end
      end
      REQ: begin
        // code stays frozen here; re-arbitration only happens from IDLE
        if (bus.ack) begin
          state_d = IDLE;
          code_d  = 2'd0;
          ack_set = 3'b001 << (code_q - 2'd1);
        end else if (!bus.ie) begin
          state_d = IDLE;
          code_d  = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = 2'd0;
      end
    endcase
  end

  // eret acts on the prior leds value, then the ack set lands; a fresh edge beats an ack clear
  always_comb begin
    eret_clr = (bus.eret && leds_any) ? (3'b001 << leds_top) : 3'b000;
    leds_d   = (leds_q & ~eret_clr) | ack_set;
    pend_d   = (pend_q & ~ack_set) | (acc_q & ~acc_prev_q);
  end

  always_ff @(posedge clk) begin
    if (!in_RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      leds_q     <= '0;
      state_q    <= IDLE;
      code_q     <= '0;
    end else begin
      sync1_q    <= bus.btn;
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      leds_q     <= leds_d;
      state_q    <= state_d;
      code_q     <= code_d;
    end
  end

  assign bus.BK      = (state_q == REQ);
  assign bus.code    = code_q;
  assign bus.pending = pend_q;
  assign bus.leds    = leds_q;

endmodule

// File: tb/tb_int_requester.sv
// Vector/scoreboard bench for int_requester with DEBOUNCE_CYCLES=4; expectations follow INT_NEST_EN when defined.
module tb_int_requester;

  typedef struct {
    logic       rst_n;
    logic [2:0] btn;
    logic [2:0] mask;
    logic       ie;
    logic       ack;
    logic       eret;
    int         ncyc;
    logic       bk;
    logic [1:0] code;
    logic [2:0] pend;
    logic [2:0] leds;
  } vec_t;

  typedef struct {
    logic       bk;
    logic [1:0] code;
    logic [2:0] pend;
    logic [2:0] leds;
  } exp_t;

  localparam logic [2:0] M = 3'b111;

  logic clk = 1'b0;
  logic in_RST;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  int_requester_if bus();

  int_requester #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .in_RST (in_RST),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic r, input logic [2:0] b, input logic [2:0] m,
                             input logic i, input logic a, input logic e, input int n,
                             input logic k, input logic [1:0] c, input logic [2:0] p,
                             input logic [2:0] l);
    vec_t v;
    v.rst_n = r; v.btn = b; v.mask = m; v.ie = i; v.ack = a; v.eret = e; v.ncyc = n;
    v.bk = k; v.code = c; v.pend = p; v.leds = l;
    return v;
  endfunction

  task automatic cmp(input string tag, input int idx, input string f,
                     input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s[%0d] %s got %0h want %0h", tag, idx, f, act, want);
    end
  endtask

  // Drive at the falling edge, let ncyc rising edges pass, compare at the next falling edge.
  task automatic run_vec(input vec_t v, input string tag, input int idx);
    exp_t e;
    e.bk = v.bk; e.code = v.code; e.pend = v.pend; e.leds = v.leds;
    exp_q.push_back(e);
    in_RST   = v.rst_n;
    bus.btn  = v.btn;
    bus.mask = v.mask;
    bus.ie   = v.ie;
    bus.ack  = v.ack;
    bus.eret = v.eret;
    repeat (v.ncyc) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s[%0d] scoreboard empty", tag, idx);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, idx, "BK",      {3'b000, bus.BK},   {3'b000, e.bk});
      cmp(tag, idx, "code",    {2'b00, bus.code},  {2'b00, e.code});
      cmp(tag, idx, "pending", {1'b0, bus.pending}, {1'b0, e.pend});
      cmp(tag, idx, "leds",    {1'b0, bus.leds},   {1'b0, e.leds});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t s[$];

    // reset and idle
    tbl.push_back(V(0, 3'b000, M, 1, 0, 0, 2, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 2, 0, 0, 3'b000, 3'b000));
    // single press on source 0, exact latency, ack, eret
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 6, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 1, 0, 0, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 1, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b001));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 1, 0, 0, 3'b000, 3'b001));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));
    // ack in IDLE and eret with no handler active are ignored
    tbl.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
    // 3-cycle glitch rejected
    tbl.push_back(V(1, 3'b010, M, 1, 0, 0, 3, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));
    // 4-cycle pulse accepted while masked: pending set, no request until unmasked
    tbl.push_back(V(1, 3'b010, 3'b101, 1, 0, 0, 4, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, 3'b101, 1, 0, 0, 3, 0, 0, 3'b010, 3'b000));
    tbl.push_back(V(1, 3'b000, 3'b101, 1, 0, 0, 2, 0, 0, 3'b010, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 1, 1, 2, 3'b010, 3'b000));
    // ie withdrawal and re-presentation
    tbl.push_back(V(1, 3'b000, M, 0, 0, 0, 1, 0, 0, 3'b010, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 0, 0, 0, 2, 0, 0, 3'b010, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 1, 1, 2, 3'b010, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b010));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));
    // simultaneous sources 0 and 2: priority, then lower one waits for eret
    tbl.push_back(V(1, 3'b101, M, 1, 0, 0, 7, 0, 0, 3'b101, 3'b000));
    tbl.push_back(V(1, 3'b101, M, 1, 0, 0, 1, 1, 3, 3'b101, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b001, 3'b100));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 3, 0, 0, 3'b001, 3'b100));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 1, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b001));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));
    // new accepted edge of source 0 lands on its own ack: pending stays set
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 4, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 3, 0, 0, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 3, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 6, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 1, 0, 1, 0, 0, 3'b001, 3'b001));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 1, 0, 0, 3'b001, 3'b001));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 1, 1, 0, 0, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b001, M, 1, 0, 0, 1, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b001));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));

    in_RST = 1'b0; bus.btn = '0; bus.mask = M; bus.ie = 1'b1; bus.ack = 1'b0; bus.eret = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "tbl", i);

    // frozen code while a higher source arrives, then nesting and ack+eret ordering
    s.push_back(V(1, 3'b001, M, 1, 0, 0, 8, 1, 1, 3'b001, 3'b000));
    s.push_back(V(1, 3'b100, M, 1, 0, 0, 7, 1, 1, 3'b101, 3'b000));
    s.push_back(V(1, 3'b100, M, 1, 1, 0, 1, 0, 0, 3'b100, 3'b001));
`ifdef INT_NEST_EN
    s.push_back(V(1, 3'b100, M, 1, 0, 0, 1, 1, 3, 3'b100, 3'b001));
    s.push_back(V(1, 3'b100, M, 1, 1, 1, 1, 0, 0, 3'b000, 3'b100));
    s.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
`else
    s.push_back(V(1, 3'b100, M, 1, 0, 0, 1, 0, 0, 3'b100, 3'b001));
    s.push_back(V(1, 3'b100, M, 1, 0, 1, 1, 0, 0, 3'b100, 3'b000));
    s.push_back(V(1, 3'b100, M, 1, 0, 0, 1, 1, 3, 3'b100, 3'b000));
    s.push_back(V(1, 3'b100, M, 1, 1, 1, 1, 0, 0, 3'b000, 3'b100));
    s.push_back(V(1, 3'b000, M, 1, 0, 1, 1, 0, 0, 3'b000, 3'b000));
`endif
    s.push_back(V(1, 3'b000, M, 1, 0, 0, 8, 0, 0, 3'b000, 3'b000));
    for (int i = 0; i < s.size(); i++) run_vec(s[i], "nest", i);
    s.delete();

    // reset with a handler in service, button held through reset
    s.push_back(V(1, 3'b001, M, 1, 0, 0, 8, 1, 1, 3'b001, 3'b000));
    s.push_back(V(1, 3'b010, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b001));
    s.push_back(V(1, 3'b010, M, 1, 0, 0, 6, 0, 0, 3'b010, 3'b001));
`ifdef INT_NEST_EN
    s.push_back(V(1, 3'b010, M, 1, 0, 0, 1, 1, 2, 3'b010, 3'b001));
`else
    s.push_back(V(1, 3'b010, M, 1, 0, 0, 1, 0, 0, 3'b010, 3'b001));
`endif
    s.push_back(V(0, 3'b010, M, 1, 0, 0, 1, 0, 0, 3'b000, 3'b000));
    s.push_back(V(1, 3'b010, M, 1, 0, 0, 7, 0, 0, 3'b010, 3'b000));
    s.push_back(V(1, 3'b010, M, 1, 0, 0, 1, 1, 2, 3'b010, 3'b000));
    s.push_back(V(1, 3'b000, M, 1, 1, 0, 1, 0, 0, 3'b000, 3'b010));
    for (int i = 0; i < s.size(); i++) run_vec(s[i], "rst", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
